// File: rtl/audio_mix_n.sv
`default_nettype none
// ============================================================================
// Module   : audio_mix_n
// Purpose  : N-channel audio mixer with per-channel gain and enable. It keeps
//            the most recent sample of every source. When frame_start arrives
//            it mixes them with one time-multiplexed MAC, then saturates the
//            result to DATA_W bits.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            ch_valid/ch_data    - per-channel sample strobes and samples
//            ch_en               - per-channel enable (0 = muted)
//            frame_start         - one-cycle mix request
//            gain_wr/addr/wdata  - shadow gain write port
//            busy                - mix in progress
//            dout/dout_valid     - mixed sample and its one-cycle strobe
//            clip                - saturation flag, pulses with dout_valid
//            frame_overrun       - frame_start dropped because busy
//            clip_cnt            - saturating count of clipped frames
// Revision : 1.0 - initial release
// ============================================================================
module audio_mix_n #(
    parameter int N_CH      = 4,
    parameter int DATA_W    = 16,
    parameter int GAIN_W    = 8,
    parameter int GAIN_FRAC = 6,
    parameter int ACC_W     = DATA_W + GAIN_W + $clog2(N_CH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         ch_valid,
    input  logic [N_CH*DATA_W-1:0]  ch_data,
    input  logic [N_CH-1:0]         ch_en,
    input  logic                    frame_start,
    input  logic                    gain_wr,
    input  logic [$clog2(N_CH)-1:0] gain_addr,
    input  logic [GAIN_W-1:0]       gain_wdata,
    output logic                    busy,
    output logic [DATA_W-1:0]       dout,
    output logic                    dout_valid,
    output logic                    clip,
    output logic                    frame_overrun,
    output logic [15:0]             clip_cnt
);

    localparam int IDX_W  = $clog2(N_CH);
    localparam int PROD_W = DATA_W + GAIN_W + 1;

    localparam logic [GAIN_W-1:0]       GAIN_UNITY = GAIN_W'(1 << GAIN_FRAC);
    localparam logic [IDX_W-1:0]        LAST_IDX   = IDX_W'(N_CH - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX    = ACC_W'((1 << (DATA_W - 1)) - 1);
    // The bitwise complement of 0..011..1 is 1..100..0, which is the most negative DATA_W value.
    localparam logic signed [ACC_W-1:0] SAT_MIN    = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_SAT   = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t state;

    logic signed [DATA_W-1:0] in_data   [N_CH];
    logic signed [DATA_W-1:0] hold      [N_CH];
    logic signed [DATA_W-1:0] next_hold [N_CH];
    logic signed [DATA_W-1:0] snap      [N_CH];
    logic [GAIN_W-1:0]        shadow    [N_CH];
    logic [GAIN_W-1:0]        next_gain [N_CH];
    logic [GAIN_W-1:0]        gain_s    [N_CH];
    logic [N_CH-1:0]          en_s;
    logic [IDX_W-1:0]         idx;
    logic signed [ACC_W-1:0]  acc;

    logic                     gain_addr_ok;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  term;
    logic signed [ACC_W-1:0]  sum;
    logic                     sat_hi;
    logic                     sat_lo;
    logic [DATA_W-1:0]        sat_val;

    assign gain_addr_ok = (int'(gain_addr) < N_CH);

    // next_hold and next_gain give the values that will be current after this
    // edge. The snapshot reads them, so a sample or gain written in the
    // frame_start cycle is already used in that mix.
    generate
        for (genvar i = 0; i < N_CH; i++) begin : g_ch
            assign in_data[i]   = ch_data[i*DATA_W +: DATA_W];
            assign next_hold[i] = ch_valid[i] ? in_data[i] : hold[i];
            assign next_gain[i] = (gain_wr && gain_addr_ok && (gain_addr == IDX_W'(i)))
                                  ? gain_wdata : shadow[i];
        end
    endgenerate

    // The gain gets a zero sign bit so that the whole 0..255 range counts as positive.
    assign prod = PROD_W'(snap[idx]) * PROD_W'($signed({1'b0, gain_s[idx]}));
    assign term = en_s[idx] ? ACC_W'(prod) : '0;

    // The arithmetic shift rounds toward minus infinity. For example, -65/64 becomes -2.
    assign sum     = acc >>> GAIN_FRAC;
    assign sat_hi  = (sum > SAT_MAX);
    assign sat_lo  = (sum < SAT_MIN);
    assign sat_val = sat_hi ? SAT_MAX[DATA_W-1:0] :
                     sat_lo ? SAT_MIN[DATA_W-1:0] : sum[DATA_W-1:0];

    assign busy          = (state != S_IDLE);
    assign frame_overrun = frame_start && busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            acc        <= '0;
            en_s       <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            clip       <= 1'b0;
            clip_cnt   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                hold[i]   <= '0;
                snap[i]   <= '0;
                shadow[i] <= GAIN_UNITY;
                gain_s[i] <= GAIN_UNITY;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                hold[i]   <= next_hold[i];
                shadow[i] <= next_gain[i];
            end
            dout_valid <= 1'b0;
            clip       <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        for (int i = 0; i < N_CH; i++) begin
                            snap[i]   <= next_hold[i];
                            gain_s[i] <= next_gain[i];
                        end
                        en_s  <= ch_en;
                        acc   <= '0;
                        idx   <= '0;
                        state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    acc <= acc + term;
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        state <= S_SAT;
                    end
                end
                S_SAT: begin
                    dout       <= sat_val;
                    clip       <= sat_hi || sat_lo;
                    dout_valid <= 1'b1;
                    state      <= S_OUT;
                end
                S_OUT: begin
                    if (clip && (clip_cnt != 16'hFFFF)) begin
                        clip_cnt <= clip_cnt + 16'd1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
